// File: rtl/lcg_stream_checker_pkg.sv
// rtl/lcg_stream_checker_pkg.sv - shared constants, state encoding and step functions for the LCG checker
// Purpose: one home for the generator recurrence constants and forward/backward step math.
// Contents: MULT/INC/INV_MULT, LOCK_COUNT/UNLOCK_ERRS/ERR_WIDTH, state enum, lcg_next/lcg_prev.
package lcg_pkg;

  localparam logic [15:0] MULT        = 16'd5;
  localparam logic [15:0] INC         = 16'd1;
  localparam logic [15:0] INV_MULT    = 16'hCCCD;  // 5 * 0xCCCD == 1 mod 2^16
  localparam logic [1:0]  LOCK_COUNT  = 2'd2;
  localparam logic [2:0]  UNLOCK_ERRS = 3'd4;
  localparam int          ERR_WIDTH   = 8;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lcg_state_e;

  // Forward step; the product is truncated to 16 bits, i.e. mod 2^16.
  function automatic logic [15:0] lcg_next(input logic [15:0] x);
    return MULT * x + INC;
  endfunction

  // Backward step: undo the increment, then multiply by the modular inverse.
  function automatic logic [15:0] lcg_prev(input logic [15:0] x);
    return INV_MULT * (x - INC);
  endfunction

endpackage

// File: rtl/lcg_stream_checker_if.sv
// rtl/lcg_stream_checker_if.sv - stream, rewind and status bundle between a source and the LCG checker
// Purpose: groups the word stream, rewind request and checker status outputs.
// master: drives InValid/InData/Rewind, observes status. slave: the checker.
interface lcg_stream_checker_if;
  import lcg_pkg::*;

  logic                 InValid;
  logic [15:0]          InData;
  logic                 Rewind;
  logic                 Locked;
  logic                 Error;
  logic [ERR_WIDTH-1:0] ErrCount;
  logic [15:0]          Expected;
  logic [15:0]          Prior;
  logic                 PriorValid;

  modport master (
    output InValid, InData, Rewind,
    input  Locked, Error, ErrCount, Expected, Prior, PriorValid
  );

  modport slave (
    input  InValid, InData, Rewind,
    output Locked, Error, ErrCount, Expected, Prior, PriorValid
  );

endinterface

// File: rtl/lcg_stream_checker_step.sv
// rtl/lcg_stream_checker_step.sv - combinational single LCG step, forward or backward
// Purpose: y = lcg_next(x) when dir = 0, y = lcg_prev(x) when dir = 1.
// Ports: dir (direction select), x (16-bit input word), y (16-bit stepped word).
module lcg_step
  import lcg_pkg::*;
(
  input  logic        dir,
  input  logic [15:0] x,
  output logic [15:0] y
);

  assign y = dir ? lcg_prev(x) : lcg_next(x);

endmodule

// File: rtl/lcg_stream_checker.sv
// rtl/lcg_stream_checker.sv - locks onto an LCG word stream, counts breaks, rewinds on request
// Purpose: tracks the 16-bit LCG sequence, flags mismatching words while locked, steps backward.
// Ports: Clock, Reset (async active-low), bus (slave modport: InValid, InData, Rewind in;
//        Locked, Error, ErrCount, Expected, Prior, PriorValid out).
module lcg_stream_checker
  import lcg_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  lcg_stream_checker_if.slave  bus
);

  localparam logic [1:0] ST_SEARCH  = SEARCH;
  localparam logic [1:0] ST_ACQUIRE = ACQUIRE;
  localparam logic [1:0] ST_LOCKED  = LOCKED;

  logic [1:0]           state_q,  state_d;
  logic [15:0]          last_q,   last_d;
  logic [15:0]          cursor_q, cursor_d;
  logic [15:0]          prior_q,  prior_d;
  logic [1:0]           match_q,  match_d;
  logic [2:0]           miss_q,   miss_d;
  logic [ERR_WIDTH-1:0] errc_q,   errc_d;
  logic                 error_q,  error_d;
  logic                 pv_q,     pv_d;
  logic [15:0]          pred;
  logic [15:0]          back;

  lcg_step u_pred (.dir(1'b0), .x(last_q),   .y(pred));
  lcg_step u_back (.dir(1'b1), .x(cursor_q), .y(back));

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cursor_d = cursor_q;
    prior_d  = prior_q;
    match_d  = match_q;
    miss_d   = miss_q;
    errc_d   = errc_q;
    error_d  = 1'b0;
    pv_d     = 1'b0;

    if (bus.InValid) begin
      case (state_q)
        ST_SEARCH: begin
          last_d  = bus.InData;
          match_d = 2'd0;
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          last_d = bus.InData;
          if (bus.InData == pred) begin
            match_d = match_q + 2'd1;
            if (match_q + 2'd1 == LOCK_COUNT) begin
              state_d = ST_LOCKED;
              match_d = 2'd0;
            end
          end else begin
            match_d = 2'd0;
          end
        end
        ST_LOCKED: begin
          if (bus.InData == pred) begin
            last_d = bus.InData;
            miss_d = 3'd0;
          end else begin
            // Flywheel on our own prediction so one bad word does not derail tracking.
            error_d = 1'b1;
            last_d  = pred;
            if (errc_q != {ERR_WIDTH{1'b1}}) errc_d = errc_q + 1'b1;
            if (miss_q + 3'd1 == UNLOCK_ERRS) begin
              state_d = ST_SEARCH;
              miss_d  = 3'd0;
            end else begin
              miss_d = miss_q + 3'd1;
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
      // An accepted word always reloads the cursor, which also drops a coincident Rewind.
      cursor_d = last_d;
    end else if (bus.Rewind && state_q != ST_SEARCH) begin
      cursor_d = back;
      prior_d  = back;
      pv_d     = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_SEARCH;
      last_q   <= 16'd0;
      cursor_q <= 16'd0;
      prior_q  <= 16'd0;
      match_q  <= 2'd0;
      miss_q   <= 3'd0;
      errc_q   <= '0;
      error_q  <= 1'b0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cursor_q <= cursor_d;
      prior_q  <= prior_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      errc_q   <= errc_d;
      error_q  <= error_d;
      pv_q     <= pv_d;
    end
  end

  assign bus.Locked     = (state_q == ST_LOCKED);
  assign bus.Error      = error_q;
  assign bus.ErrCount   = errc_q;
  assign bus.Expected   = (state_q == ST_SEARCH) ? 16'd0 : pred;
  assign bus.Prior      = prior_q;
  assign bus.PriorValid = pv_q;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// tb/tb_lcg_stream_checker.sv - self-checking bench for lcg_stream_checker
module tb_lcg_stream_checker;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lcg_stream_checker_if bus ();

  lcg_stream_checker dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  // Reference model state: 0 = searching, 1 = acquiring, 2 = locked.
  int          m_state;
  int          m_match;
  int          m_miss;
  int          m_err;
  logic [15:0] m_last;
  logic [15:0] m_cursor;
  logic [15:0] m_prior;
  logic        m_error;
  logic        m_pv;

  function automatic logic [15:0] fwd(input logic [15:0] x);
    longint t;
    t = (5 * longint'(x) + 1) % 65536;
    return 16'(t);
  endfunction

  function automatic logic [15:0] bwd(input logic [15:0] x);
    longint t;
    t = ((longint'(x) + 65535) * 52429) % 65536;
    return 16'(t);
  endfunction

  function automatic logic [15:0] model_expected();
    return (m_state == 0) ? 16'd0 : fwd(m_last);
  endfunction

  task automatic model_reset();
    m_state = 0; m_match = 0; m_miss = 0; m_err = 0;
    m_last = 0; m_cursor = 0; m_prior = 0; m_error = 0; m_pv = 0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic r);
    m_error = 0;
    m_pv    = 0;
    if (v) begin
      if (m_state == 0) begin
        m_last = d; m_match = 0; m_state = 1;
      end else if (m_state == 1) begin
        if (d == fwd(m_last)) begin
          m_match++;
          if (m_match == 2) begin m_state = 2; m_match = 0; end
        end else m_match = 0;
        m_last = d;
      end else begin
        if (d == fwd(m_last)) begin
          m_last = d; m_miss = 0;
        end else begin
          m_error = 1;
          if (m_err < 255) m_err++;
          m_last = fwd(m_last);
          m_miss++;
          if (m_miss == 4) begin m_state = 0; m_miss = 0; end
        end
      end
      m_cursor = m_last;
    end else if (r && m_state != 0) begin
      m_cursor = bwd(m_cursor);
      m_prior  = m_cursor;
      m_pv     = 1;
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    bus.InValid = v;
    bus.InData  = d;
    bus.Rewind  = r;
    @(posedge Clock);
    model_step(v, d, r);
    #1;
    bus.InValid = 1'b0;
    bus.Rewind  = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    model_reset();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    #1;
    checks++;
    if ({bus.Locked, bus.Error, bus.PriorValid} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.Locked, bus.Error, bus.PriorValid});
    end
    checks++;
    if ({bus.ErrCount, bus.Expected, bus.Prior} !== 40'd0) begin
      failures++; $display("FAIL reset_values got=%h exp=0", {bus.ErrCount, bus.Expected, bus.Prior});
    end
    do_reset();
  endtask

  task automatic test_acquire();
    do_reset();
    drive(1, 16'h0000, 0);
    checks++;
    if (bus.Expected !== 16'h0001) begin failures++; $display("FAIL acq_expected0 got=%h exp=0001", bus.Expected); end
    drive(1, 16'h0001, 0);
    checks++;
    if (bus.Locked !== 1'b0) begin failures++; $display("FAIL acq_early_lock got=%b exp=0", bus.Locked); end
    drive(1, 16'h0006, 0);
    checks++;
    if (bus.Locked !== 1'b1) begin failures++; $display("FAIL acq_locked got=%b exp=1", bus.Locked); end
    checks++;
    if (bus.Expected !== 16'h001F) begin failures++; $display("FAIL acq_expected got=%h exp=001f", bus.Expected); end
  endtask

  task automatic test_flywheel();
    drive(1, 16'h1234, 0);
    checks++;
    if ({bus.Error, bus.ErrCount, bus.Locked} !== {1'b1, 8'd1, 1'b1}) begin
      failures++; $display("FAIL fly_miss err/cnt/lock got=%b/%0d/%b exp=1/1/1", bus.Error, bus.ErrCount, bus.Locked);
    end
    drive(1, 16'h009C, 0);
    checks++;
    if ({bus.Error, bus.ErrCount, bus.Locked} !== {1'b0, 8'd1, 1'b1}) begin
      failures++; $display("FAIL fly_match err/cnt/lock got=%b/%0d/%b exp=0/1/1", bus.Error, bus.ErrCount, bus.Locked);
    end
    checks++;
    if (bus.Expected !== 16'h030D) begin failures++; $display("FAIL fly_expected got=%h exp=030d", bus.Expected); end
  endtask

  task automatic test_rewind();
    logic [15:0] exp_prior [3];
    exp_prior[0] = 16'h001F; exp_prior[1] = 16'h0006; exp_prior[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'h0000, 1);
      checks++;
      if (bus.Prior !== exp_prior[i] || bus.PriorValid !== 1'b1) begin
        failures++; $display("FAIL rewind_%0d prior/pv got=%h/%b exp=%h/1", i, bus.Prior, bus.PriorValid, exp_prior[i]);
      end
    end
    drive(0, 16'h0000, 0);
    checks++;
    if (bus.PriorValid !== 1'b0) begin failures++; $display("FAIL rewind_idle_pv got=%b exp=0", bus.PriorValid); end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    drive(1, 16'h0000, 0); drive(1, 16'h0001, 0); drive(1, 16'h0006, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, fwd(m_last) ^ 16'h5555, 0);
      checks++;
      if ({bus.Error, bus.ErrCount, bus.Locked} !== {1'b1, 8'(i + 1), (i < 3) ? 1'b1 : 1'b0}) begin
        failures++; $display("FAIL loss_%0d err/cnt/lock got=%b/%0d/%b exp=1/%0d/%b",
                             i, bus.Error, bus.ErrCount, bus.Locked, i + 1, (i < 3));
      end
    end
    checks++;
    if (bus.Expected !== 16'h0000) begin failures++; $display("FAIL loss_expected got=%h exp=0000", bus.Expected); end
    drive(1, 16'h0100, 0);
    checks++;
    if (bus.Expected !== 16'h0501 || bus.Locked !== 1'b0 || bus.ErrCount !== 8'd4) begin
      failures++; $display("FAIL loss_restart exp/lock/cnt got=%h/%b/%0d exp=0501/0/4", bus.Expected, bus.Locked, bus.ErrCount);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 16'hFFFF, 0); drive(1, 16'hFFFC, 0); drive(1, 16'hFFED, 0);
    checks++;
    if (bus.Locked !== 1'b1 || bus.Expected !== 16'hFFA2) begin
      failures++; $display("FAIL wrap_lock lock/exp got=%b/%h exp=1/ffa2", bus.Locked, bus.Expected);
    end
    do_reset();
    drive(0, 16'h0000, 1);
    checks++;
    if (bus.PriorValid !== 1'b0 || bus.Prior !== 16'h0000) begin
      failures++; $display("FAIL search_rewind pv/prior got=%b/%h exp=0/0000", bus.PriorValid, bus.Prior);
    end
    drive(1, 16'h0000, 0);
    drive(0, 16'h0000, 1);
    checks++;
    if (bus.PriorValid !== 1'b1 || bus.Prior !== 16'h3333) begin
      failures++; $display("FAIL wrap_rewind pv/prior got=%b/%h exp=1/3333", bus.PriorValid, bus.Prior);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    drive(1, 16'h0000, 0); drive(1, 16'h0001, 0);
    drive(1, 16'h0006, 1);
    checks++;
    if (bus.PriorValid !== 1'b0 || bus.Prior !== 16'h0000 || bus.Locked !== 1'b1) begin
      failures++; $display("FAIL conflict pv/prior/lock got=%b/%h/%b exp=0/0000/1", bus.PriorValid, bus.Prior, bus.Locked);
    end
    drive(0, 16'h0000, 1);
    checks++;
    if (bus.Prior !== 16'h0001) begin failures++; $display("FAIL conflict_cursor got=%h exp=0001", bus.Prior); end
  endtask

  task automatic test_saturate_reset();
    logic [15:0] s;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      s = 16'($urandom);
      drive(1, s, 0); drive(1, fwd(s), 0); drive(1, fwd(fwd(s)), 0);
      for (int i = 0; i < 4; i++) drive(1, fwd(m_last) ^ 16'h00F0, 0);
    end
    checks++;
    if (bus.ErrCount !== 8'hFF) begin failures++; $display("FAIL saturate got=%0d exp=255", bus.ErrCount); end
    drive(1, 16'h0000, 0); drive(1, 16'h0001, 0); drive(1, 16'h0006, 0);
    drive(1, 16'hBEEF, 0);
    checks++;
    if (bus.ErrCount !== 8'hFF || bus.Error !== 1'b1) begin
      failures++; $display("FAIL saturate_hold cnt/err got=%0d/%b exp=255/1", bus.ErrCount, bus.Error);
    end
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.Locked, bus.Error, bus.PriorValid, bus.ErrCount, bus.Expected, bus.Prior} !== 43'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=0",
                           {bus.Locked, bus.Error, bus.PriorValid, bus.ErrCount, bus.Expected, bus.Prior});
    end
    @(negedge Clock);
    Reset = 1'b1;
    drive(1, 16'h0042, 0);
    checks++;
    if (bus.ErrCount !== 8'd0 || bus.Expected !== fwd(16'h0042)) begin
      failures++; $display("FAIL post_reset cnt/exp got=%0d/%h exp=0/%h", bus.ErrCount, bus.Expected, fwd(16'h0042));
    end
  endtask

  task automatic test_random();
    logic [15:0] gen;
    logic [15:0] d;
    logic        v;
    logic        r;
    int          p;
    do_reset();
    gen = 16'($urandom);
    for (int i = 0; i < 1500; i++) begin
      p = int'($urandom_range(0, 15));
      v = (p < 12);
      if (p == 0) gen = 16'($urandom);
      if (v) gen = fwd(gen);
      d = (p == 1) ? 16'($urandom) : gen;
      r = ($urandom_range(0, 3) == 0);
      drive(v, d, r);
      checks++;
      if (bus.Locked !== (m_state == 2)) begin
        failures++; $display("FAIL rnd_locked @%0d got=%b exp=%b", i, bus.Locked, (m_state == 2));
      end
      checks++;
      if (bus.Error !== m_error) begin failures++; $display("FAIL rnd_error @%0d got=%b exp=%b", i, bus.Error, m_error); end
      checks++;
      if (bus.ErrCount !== 8'(m_err)) begin failures++; $display("FAIL rnd_errcount @%0d got=%0d exp=%0d", i, bus.ErrCount, m_err); end
      checks++;
      if (bus.Expected !== model_expected()) begin
        failures++; $display("FAIL rnd_expected @%0d got=%h exp=%h", i, bus.Expected, model_expected());
      end
      checks++;
      if (bus.Prior !== m_prior) begin failures++; $display("FAIL rnd_prior @%0d got=%h exp=%h", i, bus.Prior, m_prior); end
      checks++;
      if (bus.PriorValid !== m_pv) begin failures++; $display("FAIL rnd_priorvalid @%0d got=%b exp=%b", i, bus.PriorValid, m_pv); end
    end
  endtask

  initial begin
    bus.InValid = 1'b0;
    bus.InData  = 16'h0000;
    bus.Rewind  = 1'b0;
    model_reset();
    test_reset();
    test_acquire();
    test_flywheel();
    test_rewind();
    test_loss_of_lock();
    test_wrap();
    test_conflict();
    test_saturate_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
